// File: rtl/sar_conv_sequencer_if.sv
// Signal bundle between the SAR conversion sequencer, the SPI register file and the analog front end.
// The slave modport is the sequencer's view; the master modport is the register-file/AFE side.
interface sar_conv_sequencer_if #(
  parameter int ADC_WIDTH = 12
);
  logic                 adc_en;
  logic                 start;
  logic                 auto_mode;
  logic                 clk_sel;
  logic                 comparator;
  logic                 data_ack;
  logic [ADC_WIDTH-1:0] dac;
  logic                 sample_and_hold;
  logic                 pwr_gate;
  logic                 dac_rst;
  logic                 busy;
  logic                 eoc;
  logic [ADC_WIDTH-1:0] result;
  logic                 result_valid;
  logic                 overrun;

  modport master (
    output adc_en, start, auto_mode, clk_sel, comparator, data_ack,
    input  dac, sample_and_hold, pwr_gate, dac_rst, busy, eoc, result, result_valid, overrun
  );

  modport slave (
    input  adc_en, start, auto_mode, clk_sel, comparator, data_ack,
    output dac, sample_and_hold, pwr_gate, dac_rst, busy, eoc, result, result_valid, overrun
  );
endinterface

// File: rtl/sar_conv_sequencer.sv
// SAR ADC conversion sequencer: bit-clock divider, sample/bit-trial FSM, result and status flags.
// Optional sticky overwrite flag is built when SAR_OVERRUN_EN is defined; otherwise overrun is tied 0.
module sar_conv_sequencer #(
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int ADC_WIDTH    = 12,
  parameter int RATE_LO      = 8000,
  parameter int RATE_HI      = 16000,
  parameter int CONV_TICKS   = ADC_WIDTH + 2
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  sar_conv_sequencer_if.slave   bus
);

  localparam int DIV_LO = SYS_CLK_FREQ / (RATE_LO * CONV_TICKS);
  localparam int DIV_HI = SYS_CLK_FREQ / (RATE_HI * CONV_TICKS);
  localparam int BW     = $clog2(ADC_WIDTH);
  localparam logic [15:0]          DIV_LO_M1 = 16'(DIV_LO - 1);
  localparam logic [15:0]          DIV_HI_M1 = 16'(DIV_HI - 1);
  localparam logic [ADC_WIDTH-1:0] DAC_MSB   = {1'b1, {(ADC_WIDTH-1){1'b0}}};
  localparam logic [BW-1:0]        BIT_TOP   = BW'(ADC_WIDTH - 1);
  localparam logic [BW-1:0]        BIT_ONE   = {{(BW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 sel_q, sel_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [ADC_WIDTH-1:0] dac_q, dac_d;
  logic                 sh_q, sh_d;
  logic                 dac_rst_q, dac_rst_d;
  logic                 busy_q, busy_d;
  logic                 eoc_q, eoc_d;
  logic [ADC_WIDTH-1:0] result_q, result_d;
  logic                 rv_q, rv_d;
  logic                 ovr_q, ovr_d;
  logic                 pwr_q;
  logic [1:0]           sync_q;
  logic                 tick_s;
  logic                 done_s;
  logic [ADC_WIDTH-1:0] trial_s;

  assign tick_s = (cnt_q == (sel_q ? DIV_HI_M1 : DIV_LO_M1));

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      sel_q     <= 1'b0;
      bit_q     <= {BW{1'b0}};
      dac_q     <= {ADC_WIDTH{1'b0}};
      sh_q      <= 1'b0;
      dac_rst_q <= 1'b0;
      busy_q    <= 1'b0;
      eoc_q     <= 1'b0;
      result_q  <= {ADC_WIDTH{1'b0}};
      rv_q      <= 1'b0;
      ovr_q     <= 1'b0;
      pwr_q     <= 1'b0;
      sync_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      bit_q     <= bit_d;
      dac_q     <= dac_d;
      sh_q      <= sh_d;
      dac_rst_q <= dac_rst_d;
      busy_q    <= busy_d;
      eoc_q     <= eoc_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      ovr_q     <= ovr_d;
      pwr_q     <= bus.adc_en;
      sync_q    <= {sync_q[0], bus.comparator};
    end
  end

  // Next-state, divider and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = tick_s ? 16'd0 : (cnt_q + 16'd1);
    sel_d     = sel_q;
    bit_d     = bit_q;
    dac_d     = dac_q;
    sh_d      = sh_q;
    dac_rst_d = dac_rst_q;
    busy_d    = busy_q;
    eoc_d     = 1'b0;
    result_d  = result_q;
    done_s    = 1'b0;
    trial_s   = dac_q;

    if ((state_q != S_IDLE) && !bus.adc_en) begin
      // Loss of enable abandons the conversion without touching the last result.
      state_d   = S_IDLE;
      dac_d     = {ADC_WIDTH{1'b0}};
      dac_rst_d = 1'b1;
      busy_d    = 1'b0;
      sh_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dac_d     = {ADC_WIDTH{1'b0}};
          dac_rst_d = 1'b1;
          busy_d    = 1'b0;
          sh_d      = 1'b0;
          if (bus.adc_en && (bus.start || bus.auto_mode)) begin
            sel_d   = bus.clk_sel;
            cnt_d   = 16'd0;
            state_d = S_SAMPLE;
            busy_d  = 1'b1;
            sh_d    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SAMPLE: begin
          if (tick_s) begin
            sh_d      = 1'b0;
            dac_rst_d = 1'b0;
            dac_d     = DAC_MSB;
            bit_d     = BIT_TOP;
            state_d   = S_CONVERT;
          end else begin
            sh_d      = 1'b1;
            dac_rst_d = 1'b1;
            dac_d     = {ADC_WIDTH{1'b0}};
          end
        end
        S_CONVERT: begin
          if (tick_s) begin
            if (!sync_q[1]) begin
              trial_s[bit_q] = 1'b0;
            end else begin
              trial_s[bit_q] = 1'b1;
            end
            if (bit_q != {BW{1'b0}}) begin
              trial_s[bit_q - BIT_ONE] = 1'b1;
              bit_d = bit_q - BIT_ONE;
            end else begin
              state_d = S_DONE;
            end
            dac_d = trial_s;
          end else begin
            dac_d = dac_q;
          end
        end
        S_DONE: begin
          if (tick_s) begin
            result_d  = dac_q;
            eoc_d     = 1'b1;
            done_s    = 1'b1;
            dac_rst_d = 1'b1;
            dac_d     = {ADC_WIDTH{1'b0}};
            if (bus.auto_mode) begin
              // Back-to-back: straight into the next sample window.
              state_d = S_SAMPLE;
              sel_d   = bus.clk_sel;
              sh_d    = 1'b1;
              busy_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
              sh_d    = 1'b0;
              busy_d  = 1'b0;
            end
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d   = S_IDLE;
          dac_d     = {ADC_WIDTH{1'b0}};
          dac_rst_d = 1'b1;
          busy_d    = 1'b0;
          sh_d      = 1'b0;
        end
      endcase
    end

    // New data wins over a same-cycle acknowledge.
    if (done_s) begin
      rv_d = 1'b1;
    end else if (bus.data_ack) begin
      rv_d = 1'b0;
    end else begin
      rv_d = rv_q;
    end

`ifdef SAR_OVERRUN_EN
    if (done_s && rv_q && !bus.data_ack) begin
      ovr_d = 1'b1;
    end else if (bus.data_ack) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
`else
    ovr_d = 1'b0;
`endif
  end

  assign bus.dac             = dac_q;
  assign bus.sample_and_hold = sh_q;
  assign bus.pwr_gate        = pwr_q;
  assign bus.dac_rst         = dac_rst_q;
  assign bus.busy            = busy_q;
  assign bus.eoc             = eoc_q;
  assign bus.result          = result_q;
  assign bus.result_valid    = rv_q;
  assign bus.overrun         = ovr_q;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
// Directed + randomized bench for sar_conv_sequencer with an ideal comparator model (vin >= dac).
module tb_sar_conv_sequencer;
  localparam int W   = 12;
  localparam int SYS = 50_000_000;
  localparam int RLO = 8000;
  localparam int RHI = 16000;
  localparam int CT  = W + 2;

  logic         sys_clk = 1'b0;
  logic         reset;
  logic [W-1:0] vin;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] dac_seen[$];
  logic [W-1:0] exp_seq[$];
  logic         mon_en = 1'b0;
  logic [W-1:0] mon_last;

  sar_conv_sequencer_if #(.ADC_WIDTH(W)) bus ();

  sar_conv_sequencer #(
    .SYS_CLK_FREQ(SYS), .ADC_WIDTH(W), .RATE_LO(RLO), .RATE_HI(RHI), .CONV_TICKS(CT)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #10 sys_clk = ~sys_clk;

  assign bus.comparator = (vin >= bus.dac);

  // Records every change of the DAC code while a conversion is being observed.
  always @(negedge sys_clk) begin
    if (!mon_en) begin
      mon_last <= {W{1'b0}};
    end else if (bus.dac !== mon_last) begin
      dac_seen.push_back(bus.dac);
      mon_last <= bus.dac;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Ideal binary search: each trial adds the next bit to the kept code, kept if vin >= trial.
  task automatic build_exp(input logic [W-1:0] v);
    logic [W-1:0] code;
    logic [W-1:0] trial;
    logic [W-1:0] prev;
    logic [W-1:0] one_v;
    one_v = 1;
    code  = 0;
    prev  = 0;
    exp_seq.delete();
    for (int b = W - 1; b >= 0; b--) begin
      trial = code | (one_v << b);
      if (trial != prev) exp_seq.push_back(trial);
      prev = trial;
      if (v >= trial) code = trial;
    end
    if (code != prev) exp_seq.push_back(code);
    prev = code;
    if (prev != 0) exp_seq.push_back({W{1'b0}});
  endtask

  function automatic int exp_cycles(input logic sel);
    return (SYS / ((sel ? RHI : RLO) * CT)) * CT + 1;
  endfunction

  task automatic wait_eoc(input int limit, output int n);
    n = 0;
    while (bus.eoc !== 1'b1 && n < limit) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  task automatic single_conv(input string tag, input logic [W-1:0] v, input logic sel, input bit mid_start);
    int n;
    int ec;
    vin = v;
    bus.clk_sel = sel;
    build_exp(v);
    dac_seen.delete();
    mon_en = 1'b1;
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    check({tag, "_busy_go"}, bus.busy, 1);
    check({tag, "_sh_track"}, bus.sample_and_hold, 1);
    n = 0;
    while (bus.eoc !== 1'b1 && n < 8000) begin
      @(negedge sys_clk);
      n++;
      bus.start = (mid_start && n == 1000) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    ec = exp_cycles(sel);
    check_range({tag, "_eoc_time"}, n + 1, ec - 1, ec + 1);
    check({tag, "_result"}, bus.result, v);
    check({tag, "_rvalid"}, bus.result_valid, 1);
    check({tag, "_busy_end"}, bus.busy, 0);
    @(negedge sys_clk);
    check({tag, "_eoc_pulse"}, bus.eoc, 0);
    mon_en = 1'b0;
    check({tag, "_seqlen"}, dac_seen.size(), exp_seq.size());
    for (int i = 0; i < dac_seen.size() && i < exp_seq.size(); i++)
      check({tag, "_dacseq"}, dac_seen[i], exp_seq[i]);
    bus.data_ack = 1'b1;
    @(negedge sys_clk);
    bus.data_ack = 1'b0;
    check({tag, "_ack_clr"}, bus.result_valid, 0);
  endtask

  initial begin
    int n;
    int eoc_cnt;
    int ec;
    logic [W-1:0] rv;
    reset         = 1'b1;
    vin           = 0;
    bus.adc_en    = 1'b0;
    bus.start     = 1'b0;
    bus.auto_mode = 1'b0;
    bus.clk_sel   = 1'b0;
    bus.data_ack  = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_dac", bus.dac, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_eoc", bus.eoc, 0);
    check("rst_result", bus.result, 0);
    check("rst_rvalid", bus.result_valid, 0);
    check("rst_ovr", bus.overrun, 0);
    check("rst_pwr", bus.pwr_gate, 0);
    check("rst_dacrst", bus.dac_rst, 0);
    check("rst_sh", bus.sample_and_hold, 0);
    reset = 1'b0;
    @(negedge sys_clk);
    check("idle_dacrst", bus.dac_rst, 1);
    bus.adc_en = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("pwr_on", bus.pwr_gate, 1);

    single_conv("t1_a52", 12'hA52, 1'b0, 1'b0);
    single_conv("t2_000", 12'h000, 1'b1, 1'b0);
    single_conv("t2_fff", 12'hFFF, 1'b1, 1'b0);
    single_conv("t3_888", 12'h888, 1'b1, 1'b1);

    // Auto mode: two back-to-back conversions, no read in between.
    vin = 12'h200;
    bus.clk_sel = 1'b1;
    bus.auto_mode = 1'b1;
    @(negedge sys_clk);
    wait_eoc(8000, n);
    ec = exp_cycles(1'b1);
    check_range("t4_eoc1_time", n + 1, ec - 1, ec + 1);
    check("t4_res1", bus.result, 12'h200);
    check("t4_ovr1", bus.overrun, 0);
    vin = 12'h999;
    bus.auto_mode = 1'b0;
    @(negedge sys_clk);
    check("t4_busy_kept", bus.busy, 1);
    check("t4_sample_next", bus.sample_and_hold, 1);
    check("t4_eoc_pulse", bus.eoc, 0);
    wait_eoc(8000, n);
    check_range("t4_eoc2_time", n + 2, ec - 1, ec + 1);
    check("t4_res2", bus.result, 12'h999);
    check("t4_rvalid", bus.result_valid, 1);
`ifdef SAR_OVERRUN_EN
    check("t6_ovr_set", bus.overrun, 1);
`else
    check("t6_ovr_tied", bus.overrun, 0);
`endif
    @(negedge sys_clk);
    check("t4_idle_after", bus.busy, 0);

    // Abort by dropping enable mid-conversion.
    vin = 12'h123;
    bus.clk_sel = 1'b0;
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    repeat (2999) @(negedge sys_clk);
    check("t5_busy_pre", bus.busy, 1);
    bus.adc_en = 1'b0;
    @(negedge sys_clk);
    check("t5_busy", bus.busy, 0);
    check("t5_dac", bus.dac, 0);
    check("t5_pwr", bus.pwr_gate, 0);
    check("t5_result", bus.result, 12'h999);
    check("t5_rvalid", bus.result_valid, 1);
    eoc_cnt = 0;
    repeat (100) begin
      @(negedge sys_clk);
      if (bus.eoc === 1'b1) eoc_cnt++;
    end
    check("t5_no_eoc", eoc_cnt, 0);
    bus.data_ack = 1'b1;
    @(negedge sys_clk);
    bus.data_ack = 1'b0;
    check("t6_ack_rv", bus.result_valid, 0);
    check("t6_ack_ovr", bus.overrun, 0);
    bus.adc_en = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("t5_pwr_back", bus.pwr_gate, 1);

    // Randomized single conversions at the fast rate.
    for (int k = 0; k < 3; k++) begin
      rv = W'($urandom_range(0, (1 << W) - 1));
      single_conv("rnd", rv, 1'b1, 1'b0);
    end

    // Reset in the middle of a conversion.
    vin = 12'h456;
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    repeat (500) @(negedge sys_clk);
    reset = 1'b1;
    @(negedge sys_clk);
    check("mrst_busy", bus.busy, 0);
    check("mrst_dac", bus.dac, 0);
    check("mrst_result", bus.result, 0);
    check("mrst_rvalid", bus.result_valid, 0);
    check("mrst_sh", bus.sample_and_hold, 0);
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("mrst_idle", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
